// File: rtl/imm_decode_controller.sv
// ============================================================================
// Module      : imm_decode_controller
// Description : Decode-stage holding register with valid/ready handshake,
//               immediate SELECT decode, load-use hazard bubbles, flush and a
//               saturating stall counter. Optional trap flag for unknown
//               opcodes is enabled by defining ILLEGAL_INSTR_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_controller #(
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   IF_VALID,
    input  logic [31:0]            IF_INSTR,
    output logic                   IF_READY,
    input  logic                   FLUSH,
    input  logic                   EX_MEM_READ,
    input  logic [4:0]             EX_RD,
    input  logic                   ID_READY,
    output logic                   ID_VALID,
    output logic [31:0]            ID_INSTR,
    output logic [2:0]             IMM_SELECT,
    output logic                   HAZARD_STALL,
    output logic [STALL_CNT_W-1:0] STALL_COUNT,
    output logic                   ILLEGAL
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

    localparam logic [2:0] c_SEL_U    = 3'b000;
    localparam logic [2:0] c_SEL_J    = 3'b001;
    localparam logic [2:0] c_SEL_I    = 3'b010;
    localparam logic [2:0] c_SEL_B    = 3'b011;
    localparam logic [2:0] c_SEL_S    = 3'b100;
    localparam logic [2:0] c_SEL_NONE = 3'b111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_instr;
    logic [2:0]             r_imm_sel;
    logic                   r_uses_rs1;
    logic                   r_uses_rs2;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [6:0] w_opcode;
    logic [2:0] w_sel;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_known;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_hazard;
    logic       w_id_valid;
    logic       w_if_ready;
    logic       w_capture;
    logic       w_transfer;

    assign w_opcode = IF_INSTR[6:0];

    // Decode the incoming opcode so the result can be registered at capture.
    always_comb begin
        w_sel      = c_SEL_NONE;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_known    = 1'b1;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC: w_sel = c_SEL_U;
            c_OP_JAL:             w_sel = c_SEL_J;
            c_OP_JALR, c_OP_LOAD, c_OP_OPIMM, c_OP_SYSTEM, c_OP_FENCE: begin
                w_sel      = c_SEL_I;
                w_uses_rs1 = 1'b1;
            end
            c_OP_BRANCH: begin
                w_sel      = c_SEL_B;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_OP_STORE: begin
                w_sel      = c_SEL_S;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_OP_OP: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_rs1_hit  = r_uses_rs1 && (r_instr[19:15] == EX_RD);
    assign w_rs2_hit  = r_uses_rs2 && (r_instr[24:20] == EX_RD);
    assign w_hazard   = (r_state == ST_FULL) && EX_MEM_READ && (EX_RD != 5'd0)
                        && (w_rs1_hit || w_rs2_hit);
    assign w_id_valid = (r_state == ST_FULL) && !w_hazard;
    assign w_if_ready = !FLUSH && ((r_state == ST_EMPTY) || (ID_READY && !w_hazard));
    assign w_capture  = IF_VALID && w_if_ready;
    assign w_transfer = w_id_valid && ID_READY;

`ifdef ILLEGAL_INSTR_TRAP_EN
    logic r_illegal;
`else
    logic unused_known;
    assign unused_known = w_known;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_EMPTY;
            r_instr     <= NOP_INSTR;
            r_imm_sel   <= c_SEL_I;
            r_uses_rs1  <= 1'b0;
            r_uses_rs2  <= 1'b0;
            r_stall_cnt <= '0;
`ifdef ILLEGAL_INSTR_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else begin
            if (w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
            if (FLUSH) begin
                r_state    <= ST_EMPTY;
                r_instr    <= NOP_INSTR;
                r_imm_sel  <= c_SEL_I;
                r_uses_rs1 <= 1'b0;
                r_uses_rs2 <= 1'b0;
`ifdef ILLEGAL_INSTR_TRAP_EN
                r_illegal  <= 1'b0;
`endif
            end else if (w_capture) begin
                r_state    <= ST_FULL;
                r_instr    <= IF_INSTR;
                r_imm_sel  <= w_sel;
                r_uses_rs1 <= w_uses_rs1;
                r_uses_rs2 <= w_uses_rs2;
`ifdef ILLEGAL_INSTR_TRAP_EN
                r_illegal  <= !w_known;
`endif
            end else if (w_transfer) begin
                // Instruction word is left in place; only the slot empties.
                r_state    <= ST_EMPTY;
`ifdef ILLEGAL_INSTR_TRAP_EN
                r_illegal  <= 1'b0;
`endif
            end
        end
    end

    assign IF_READY     = w_if_ready;
    assign ID_VALID     = w_id_valid;
    assign ID_INSTR     = r_instr;
    assign IMM_SELECT   = r_imm_sel;
    assign HAZARD_STALL = w_hazard;
    assign STALL_COUNT  = r_stall_cnt;
`ifdef ILLEGAL_INSTR_TRAP_EN
    assign ILLEGAL      = r_illegal;
`else
    assign ILLEGAL      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_controller.sv
// ============================================================================
// Module      : tb_imm_decode_controller
// Description : Self-checking bench for imm_decode_controller with a
//               behavioural model of the decode slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_controller;

    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_valid = 1'b0;
    logic [31:0]   if_instr = '0;
    logic          flush = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic          id_ready = 1'b0;
    logic          if_ready;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [2:0]    imm_select;
    logic          hazard_stall;
    logic [CW-1:0] stall_count;
    logic          illegal;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_full  = 1'b0;
    logic [31:0] m_instr = NOP;
    int          m_cnt   = 0;

    imm_decode_controller #(
        .NOP_INSTR  (NOP),
        .STALL_CNT_W(CW)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .IF_VALID    (if_valid),
        .IF_INSTR    (if_instr),
        .IF_READY    (if_ready),
        .FLUSH       (flush),
        .EX_MEM_READ (ex_mem_read),
        .EX_RD       (ex_rd),
        .ID_READY    (id_ready),
        .ID_VALID    (id_valid),
        .ID_INSTR    (id_instr),
        .IMM_SELECT  (imm_select),
        .HAZARD_STALL(hazard_stall),
        .STALL_COUNT (stall_count),
        .ILLEGAL     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Instruction format -> immediate select code.
    function automatic logic [2:0] ref_sel(input logic [6:0] op);
        case (op)
            7'h37, 7'h17:                      return 3'b000;
            7'h6f:                             return 3'b001;
            7'h67, 7'h03, 7'h13, 7'h73, 7'h0f: return 3'b010;
            7'h63:                             return 3'b011;
            7'h23:                             return 3'b100;
            default:                           return 3'b111;
        endcase
    endfunction

    function automatic bit ref_rtype(input logic [6:0] op);
        return op == 7'h33;
    endfunction

    function automatic bit ref_rs1(input logic [6:0] op);
        return (ref_sel(op) inside {3'b010, 3'b011, 3'b100}) || ref_rtype(op);
    endfunction

    function automatic bit ref_rs2(input logic [6:0] op);
        return (ref_sel(op) inside {3'b011, 3'b100}) || ref_rtype(op);
    endfunction

    function automatic bit ref_known(input logic [6:0] op);
        return (ref_sel(op) != 3'b111) || ref_rtype(op);
    endfunction

    function automatic bit m_hazard();
        logic [6:0] op;
        op = m_instr[6:0];
        return m_full && ex_mem_read && (ex_rd != 5'd0) &&
               ((ref_rs1(op) && m_instr[19:15] == ex_rd) ||
                (ref_rs2(op) && m_instr[24:20] == ex_rd));
    endfunction

    function automatic bit m_if_ready();
        return !flush && (!m_full || (id_ready && !m_hazard()));
    endfunction

    function automatic bit m_illegal();
`ifdef ILLEGAL_INSTR_TRAP_EN
        return m_full && !ref_known(m_instr[6:0]);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock, moving the model along with the DUT.
    task automatic cycle();
        bit          hz;
        bit          nf;
        logic [31:0] ni;
        int          nc;
        hz = m_hazard();
        nf = m_full;
        ni = m_instr;
        nc = m_cnt;
        if (hz && nc < (1 << CW) - 1) nc++;
        if (flush) begin
            nf = 1'b0;
            ni = NOP;
        end else if (if_valid && m_if_ready()) begin
            nf = 1'b1;
            ni = if_instr;
        end else if (m_full && !hz && id_ready) begin
            nf = 1'b0;
        end
        @(posedge clk);
        #1;
        m_full  = nf;
        m_instr = ni;
        m_cnt   = nc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({id_valid, hazard_stall, illegal, imm_select, id_instr, stall_count} !==
            {1'b0, 1'b0, 1'b0, 3'b010, NOP, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b hz=%b ill=%b sel=%b instr=%h cnt=%0d",
                     id_valid, hazard_stall, illegal, imm_select, id_instr, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_if_ready: got %b want 1", if_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] tab_i [6] = '{32'h53a4c037, 32'hb8ee306f, 32'hfe800013,
                                   32'h00208463, 32'h940005a3, 32'h40000033};
        logic [2:0]  tab_s [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        for (int i = 0; i < 6; i++) begin
            if_valid = 1'b1;
            if_instr = tab_i[i];
            id_ready = 1'b1;
            ex_mem_read = 1'b0;
            flush = 1'b0;
            #1;
            cycle();
            n_tests++;
            if ({id_valid, imm_select, id_instr} !== {1'b1, tab_s[i], tab_i[i]}) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b sel=%b instr=%h want v=1 sel=%b instr=%h",
                         i, id_valid, imm_select, id_instr, tab_s[i], tab_i[i]);
            end
        end
        if_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        if_valid = 1'b1;
        if_instr = 32'h00500093;
        id_ready = 1'b1;
        #1;
        cycle();
        if_instr = 32'h00112023;
        id_ready = 1'b0;
        repeat (3) begin
            #1;
            n_tests++;
            if ({if_ready, id_valid, imm_select, id_instr} !==
                {1'b0, 1'b1, 3'b010, 32'h00500093}) begin
                n_fail++;
                $display("FAIL backpressure_hold: got rdy=%b v=%b sel=%b instr=%h",
                         if_ready, id_valid, imm_select, id_instr);
            end
            cycle();
        end
        id_ready = 1'b1;
        #1;
        n_tests++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release_ready: got %b want 1", if_ready);
        end
        cycle();
        n_tests++;
        if ({id_valid, imm_select, id_instr} !== {1'b1, 3'b100, 32'h00112023}) begin
            n_fail++;
            $display("FAIL backpressure_refill: got v=%b sel=%b instr=%h want v=1 sel=100 instr=00112023",
                     id_valid, imm_select, id_instr);
        end
        if_valid = 1'b0;
        cycle();
    endtask

    task automatic test_load_use();
        if_valid = 1'b1;
        if_instr = 32'h00208133;
        id_ready = 1'b1;
        ex_mem_read = 1'b0;
        #1;
        cycle();
        if_valid = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd = 5'd1;
        #1;
        n_tests++;
        if ({hazard_stall, id_valid, if_ready, stall_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL load_use_stall: got hz=%b v=%b rdy=%b cnt=%0d want hz=1 v=0 rdy=0 cnt=0",
                     hazard_stall, id_valid, if_ready, stall_count);
        end
        cycle();
        n_tests++;
        if ({stall_count, id_instr} !== {CW'(1), 32'h00208133}) begin
            n_fail++;
            $display("FAIL load_use_count: got cnt=%0d instr=%h want cnt=1 instr=00208133",
                     stall_count, id_instr);
        end
        ex_mem_read = 1'b0;
        #1;
        n_tests++;
        if ({id_valid, hazard_stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_use_release: got v=%b hz=%b want v=1 hz=0", id_valid, hazard_stall);
        end
        cycle();
    endtask

    task automatic test_no_false_hazard();
        if_valid = 1'b1;
        if_instr = 32'h0002d2b7;
        id_ready = 1'b1;
        ex_mem_read = 1'b0;
        #1;
        cycle();
        if_valid = 1'b0;
        id_ready = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        #1;
        n_tests++;
        if ({hazard_stall, id_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL no_hazard_lui: got hz=%b v=%b want hz=0 v=1", hazard_stall, id_valid);
        end
        ex_mem_read = 1'b0;
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00000033;
        #1;
        cycle();
        if_valid = 1'b0;
        id_ready = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd = 5'd0;
        #1;
        n_tests++;
        if ({hazard_stall, id_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL no_hazard_rd0: got hz=%b v=%b want hz=0 v=1", hazard_stall, id_valid);
        end
        ex_mem_read = 1'b0;
        id_ready = 1'b1;
        cycle();
    endtask

    task automatic test_flush();
        if_valid = 1'b1;
        if_instr = 32'h00c58563;
        id_ready = 1'b0;
        #1;
        cycle();
        flush = 1'b1;
        if_instr = 32'h00000537;
        #1;
        n_tests++;
        if (if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_if_ready: got %b want 0", if_ready);
        end
        cycle();
        flush = 1'b0;
        if_valid = 1'b0;
        #1;
        n_tests++;
        if ({id_valid, if_ready, imm_select, id_instr} !== {1'b0, 1'b1, 3'b010, NOP}) begin
            n_fail++;
            $display("FAIL flush_result: got v=%b rdy=%b sel=%b instr=%h want v=0 rdy=1 sel=010 instr=%h",
                     id_valid, if_ready, imm_select, id_instr, NOP);
        end
    endtask

    task automatic test_saturation();
        if_valid = 1'b1;
        if_instr = 32'h00208133;
        id_ready = 1'b0;
        ex_mem_read = 1'b0;
        #1;
        cycle();
        if_valid = 1'b0;
        ex_mem_read = 1'b1;
        ex_rd = 5'd2;
        repeat (20) cycle();
        n_tests++;
        if (stall_count !== {CW{1'b1}} || int'(stall_count) != m_cnt) begin
            n_fail++;
            $display("FAIL stall_saturate: got %0d want %0d", stall_count, (1 << CW) - 1);
        end
        ex_mem_read = 1'b0;
    endtask

    task automatic test_async_reset();
        logic e_ill;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({id_valid, hazard_stall, illegal, imm_select, id_instr, stall_count} !==
            {1'b0, 1'b0, 1'b0, 3'b010, NOP, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b hz=%b ill=%b sel=%b instr=%h cnt=%0d",
                     id_valid, hazard_stall, illegal, imm_select, id_instr, stall_count);
        end
        m_full = 1'b0;
        m_instr = NOP;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_release: got if_ready=%b want 1", if_ready);
        end
        if_valid = 1'b1;
        if_instr = 32'h1234567f;
        cycle();
        if_valid = 1'b0;
        #1;
`ifdef ILLEGAL_INSTR_TRAP_EN
        e_ill = 1'b1;
`else
        e_ill = 1'b0;
`endif
        n_tests++;
        if ({illegal, imm_select, id_valid} !== {e_ill, 3'b111, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_opcode: got ill=%b sel=%b v=%b want ill=%b sel=111 v=1",
                     illegal, imm_select, id_valid, e_ill);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13,
                                  7'h73, 7'h0f, 7'h63, 7'h23, 7'h33, 7'h7f};
        logic [31:0] ins;
        logic [59:0] exp_v;
        logic [59:0] got_v;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
            ins[19:15]  = 5'($urandom_range(0, 3));
            ins[24:20]  = 5'($urandom_range(0, 3));
            if_instr    = ins;
            if_valid    = 1'($urandom_range(0, 1));
            id_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            #1;
            exp_v = {16'h0, m_full && !m_hazard(), m_if_ready(), m_hazard(), m_illegal(),
                     ref_sel(m_instr[6:0]), m_instr, 4'(m_cnt)};
            got_v = {16'h0, id_valid, if_ready, hazard_stall, illegal,
                     imm_select, id_instr, 4'(stall_count)};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: got {v,rdy,hz,ill,sel,instr,cnt}=%h want %h",
                         i, got_v, exp_v);
            end
            cycle();
        end
        if_valid = 1'b0;
        flush = 1'b0;
        ex_mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
